arbitrate: RTL and testbench
============================

# arbitrate

Round-robin arbiter that merges N independent stb/rdy requester streams into one registered master stream. It is the fan-in counterpart of the broadcast fan-out stage: it lets several producers share one downstream consumer, such as a single layer input or a broadcast stage. Arbitration is message-granular: once a requester is granted, it keeps the output until it delivers a beat with `lst` set. Each output beat is tagged with the index of its source.

## Interface
Parameters:
- `W`, 8: data width per beat.
- `N`, 2: number of requesters, N ≥ 2.
- `I`, derived `$clog2(N)`: index width; not user-set.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_stb`  in  N  per-requester valid.
- `s_dat`  in  N*W  requester data; requester i in bits [i*W +: W].
- `s_lst`  in  N  per-requester last-beat-of-message flag.
- `s_rdy`  out  N  per-requester accept; at most one bit high.
- `m_rdy`  in  1  downstream accept.
- `m_stb`  out  1  output valid, registered.
- `m_dat`  out  W  output data, registered.
- `m_lst`  out  1  output last flag, registered.
- `m_idx`  out  I  source index of the current output beat, registered.

## Operation
- A transfer occurs on any interface when stb and rdy are both high at a rising edge.
- State machine:
  - IDLE: no grant is held.
    - If any `s_stb` bit is high, select the first requester at or after `ptr`, wrapping modulo N.
    - Register that requester as `gnt` and move to BUSY.
    - If no requests, stay in IDLE.
  - BUSY: `s_rdy[gnt] = ~m_stb | m_rdy`; all other `s_rdy` bits are 0.
    - On an accepted beat, load the output register with {dat, lst, idx=gnt} and set `m_stb`.
    - If the accepted beat has `lst` = 1, go to IDLE and set `ptr <= (gnt+1) mod N`, wrapping from N-1 to 0.
- Output register:
  - `m_stb` clears on `m_rdy` unless a new beat is loaded in the same cycle.
  - While `m_stb & ~m_rdy`, `m_dat`, `m_lst` and `m_idx` hold stable.
- If the granted requester deasserts `s_stb` mid-message, the grant is held. There is no timeout, and other requesters wait.
- Requests from non-granted sources are never accepted and never dropped; they stay pending.
- `s_rdy` is zero in IDLE.

## Timing
- Reset values: `state`=IDLE, `ptr`=0, `gnt`=0, `m_stb`=0, `m_dat`=0, `m_lst`=0, `m_idx`=0, so all `s_rdy` bits are 0.
- Reset is asynchronous and takes effect immediately. Any in-flight output beat and any held grant are discarded.
- Arbitration latency: a request seen in IDLE at edge k gives grant at k+1. The first beat can be accepted at edge k+1, and `m_stb` is high after k+1.
- Accept-to-output latency: 1 cycle.
- Full throughput within a message: 1 beat per cycle while `m_rdy` stays high.
- Message boundary cost: exactly one idle cycle (the IDLE arbitration cycle) between the `lst` beat and the next message's first beat, even when requesting from the same source.
- Single-beat message (`lst` = 1 on the first beat): BUSY lasts one accepted beat.
- `s_rdy` is combinational from `state`, `gnt`, `m_stb` and `m_rdy` only. It never depends on `s_stb`.

## Structure
- Shared package `arbitrate_pkg`:
  - state encoding constants `ST_IDLE`=0 and `ST_BUSY`=1;
  - a clog2 function for index width, with a minimum of 1.
- Sub-module `rr_select`: combinational rotating-priority encoder.
  - Inputs: `req[N-1:0]`, `ptr[I-1:0]`.
  - Outputs: `any`, `sel[I-1:0]`.
  - Unit-tested on its own.
- Top level: state register, grant and pointer registers, output register, and the `s_rdy` decode.

## Test plan
- **Reset:** hold `rst_n`=0 with all `s_stb` high → `s_rdy`=0, `m_stb`=0 and `m_idx`=0. Release reset → first grant goes to requester 0; its beat 0xA5 appears on `m_dat` 2 cycles after release with `m_idx`=0.
- **Fairness:** N=4, all requesters send continuous single-beat messages with `m_rdy`=1 → `m_idx` sequence 0,1,2,3,0,1,… with exactly one idle cycle between consecutive beats.
- **Message lock:** requester 1 sends 3 beats 0x10, 0x11, 0x12 (last). Requester 0 requests starting with beat 2 → output is 0x10, 0x11, 0x12 from idx 1, then requester 0's beat. `s_rdy[0]` stays 0 throughout.
- **Backpressure:** `m_rdy`=0 for 5 cycles with a beat pending → `m_dat` is stable, `m_stb`=1, and `s_rdy[gnt]`=0. Release `m_rdy` → no beat is lost or duplicated (scoreboard per source).
- **Stall mid-message:** granted requester drops `s_stb` for 4 cycles between beats → grant is held, other requesters are not served, and the message resumes intact.
- **Async reset mid-message:** assert `rst_n`=0 between edges during beat 2 of 4 → `m_stb` falls immediately without waiting for an edge. After release, `ptr`=0 and arbitration restarts from requester 0.

Source files
------------

// File: rtl/arbitrate_pkg.sv
// Shared definitions for the round-robin message arbiter: state encoding and
// index-width helper.
package arbitrate_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Bits needed to index n requesters, never less than one.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Rotating-priority encoder: picks the first asserted request at or after ptr,
// wrapping modulo N.
module rr_select
  import arbitrate_pkg::*;
#(
  parameter int N = 2,
  parameter int I = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [I-1:0] ptr,
  output logic         any,
  output logic [I-1:0] sel
);

  // Walk from the farthest offset toward ptr so the nearest request wins.
  always_comb begin
    int w_idx;
    w_idx = 0;
    any   = |req;
    sel   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (req[w_idx]) sel = I'(w_idx);
    end
  end

endmodule

// File: rtl/arbitrate.sv
// Round-robin, message-granular fan-in of N stb/rdy requesters onto one
// registered master stream; each output beat carries its source index.
//
// state   | meaning
// ST_IDLE | no grant held; next requester chosen from r_ptr this cycle
// ST_BUSY | r_gnt owns the output until its lst beat is accepted
module arbitrate
  import arbitrate_pkg::*;
#(
  parameter  int W = 8,
  parameter  int N = 2,
  localparam int I = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   s_stb,
  input  logic [N*W-1:0] s_dat,
  input  logic [N-1:0]   s_lst,
  output logic [N-1:0]   s_rdy,
  input  logic           m_rdy,
  output logic           m_stb,
  output logic [W-1:0]   m_dat,
  output logic           m_lst,
  output logic [I-1:0]   m_idx
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [I-1:0] r_gnt;
  logic [I-1:0] r_ptr;
  logic         r_m_stb;
  logic [W-1:0] r_m_dat;
  logic         r_m_lst;
  logic [I-1:0] r_m_idx;

  logic         w_any;
  logic [I-1:0] w_sel;
  logic         w_out_free;
  logic         w_acc;
  logic         w_acc_lst;
  logic [W-1:0] w_gnt_dat;
  logic [I-1:0] w_ptr_nxt;

  rr_select #(
    .N (N),
    .I (I)
  ) u_rr_select (
    .req (s_stb),
    .ptr (r_ptr),
    .any (w_any),
    .sel (w_sel)
  );

  // Output slot can take a beat when empty or being drained this cycle.
  assign w_out_free = ~r_m_stb | m_rdy;
  assign w_gnt_dat  = s_dat[int'(r_gnt)*W +: W];
  assign w_acc      = (r_state == ST_BUSY) & s_stb[r_gnt] & w_out_free;
  assign w_acc_lst  = w_acc & s_lst[r_gnt];
  assign w_ptr_nxt  = (int'(r_gnt) == N - 1) ? '0 : r_gnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any)     w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_acc_lst) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Ready never looks at s_stb, so it cannot form a loop with the requesters.
  always_comb begin
    s_rdy = '0;
    if (r_state == ST_BUSY) s_rdy[r_gnt] = w_out_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_ptr <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any) r_gnt <= w_sel;
      if (w_acc_lst)                     r_ptr <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_stb <= 1'b0;
      r_m_dat <= '0;
      r_m_lst <= 1'b0;
      r_m_idx <= '0;
    end else if (w_acc) begin
      r_m_stb <= 1'b1;
      r_m_dat <= w_gnt_dat;
      r_m_lst <= s_lst[r_gnt];
      r_m_idx <= r_gnt;
    end else if (m_rdy) begin
      r_m_stb <= 1'b0;
    end
  end

  assign m_stb = r_m_stb;
  assign m_dat = r_m_dat;
  assign m_lst = r_m_lst;
  assign m_idx = r_m_idx;

endmodule

// File: tb/tb_arbitrate.sv
// Bench for arbitrate (N=4): per-source beat queues feed a cycle reference
// model built from the arbitration rules; directed scenarios then random traffic.
module tb_arbitrate;
  import arbitrate_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int I  = 2;
  localparam int QD = 1024;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   s_stb;
  logic [N*W-1:0] s_dat;
  logic [N-1:0]   s_lst;
  logic [N-1:0]   s_rdy;
  logic           m_rdy;
  logic           m_stb;
  logic [W-1:0]   m_dat;
  logic           m_lst;
  logic [I-1:0]   m_idx;

  logic [N-1:0]   u_req = '0;
  logic [I-1:0]   u_ptr = '0;
  logic           u_any;
  logic [I-1:0]   u_sel;

  int nvec = 0;
  int nerr = 0;

  logic [W:0]   qmem [N][QD];
  int           qhd  [N];
  int           qtl  [N];
  logic [N-1:0] en;
  int           sent [N];
  int           rcvd [N];
  int           out_log[$];

  bit           mb;
  int           mg;
  int           mp;
  bit           mv;
  logic [W-1:0] md;
  bit           ml;
  int           mi;

  always #5 clk = ~clk;

  arbitrate #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_stb (s_stb),
    .s_dat (s_dat),
    .s_lst (s_lst),
    .s_rdy (s_rdy),
    .m_rdy (m_rdy),
    .m_stb (m_stb),
    .m_dat (m_dat),
    .m_lst (m_lst),
    .m_idx (m_idx)
  );

  rr_select #(.N(N), .I(I)) u_sel_dut (
    .req (u_req),
    .ptr (u_ptr),
    .any (u_any),
    .sel (u_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int src, input logic [W-1:0] dat, input bit lst);
    if (qtl[src] < QD) begin
      qmem[src][qtl[src]] = {lst, dat};
      qtl[src]++;
    end
  endtask

  task automatic push_msg(input int src, input int len);
    for (int b = 0; b < len; b++) push(src, W'($urandom_range(255, 0)), b == len - 1);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      qhd[i]  = 0;
      qtl[i]  = 0;
      sent[i] = 0;
      rcvd[i] = 0;
    end
  endtask

  task automatic model_reset();
    mb = 0; mg = 0; mp = 0; mv = 0; md = '0; ml = 0; mi = 0;
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1;
    for (int i = 0; i < N; i++) if (qhd[i] != qtl[i]) e = 0;
    return e;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [W:0] b;
      b = qmem[i][qhd[i]];
      s_stb[i] = en[i] && (qhd[i] != qtl[i]);
      s_dat[i*W +: W] = s_stb[i] ? b[W-1:0] : '0;
      s_lst[i] = s_stb[i] & b[W];
    end
  endtask

  // One clock: drive at the falling edge, compare, predict, advance.
  task automatic step();
    logic [N-1:0] rdy_exp;
    bit           acc;
    bit           n_b;
    int           n_g;
    int           n_p;
    bit           n_v;
    logic [W-1:0] n_d;
    bit           n_l;
    int           n_i;
    drive();
    #1;
    rdy_exp = '0;
    if (mb && (!mv || m_rdy)) rdy_exp[mg] = 1'b1;
    check("s_rdy", s_rdy, rdy_exp);
    check("m_stb", m_stb, mv);
    check("m_dat", m_dat, md);
    check("m_lst", m_lst, ml);
    check("m_idx", m_idx, mi);
    if (rst_n && m_stb && m_rdy) begin
      rcvd[m_idx]++;
      out_log.push_back(int'(m_idx) * 256 + int'(m_dat));
    end
    n_b = mb; n_g = mg; n_p = mp; n_v = mv; n_d = md; n_l = ml; n_i = mi;
    acc = 0;
    if (rst_n) begin
      if (!mb) begin
        for (int k = 0; k < N; k++)
          if (!n_b && s_stb[(mp + k) % N]) begin
            n_b = 1;
            n_g = (mp + k) % N;
          end
      end else if (s_stb[mg] && rdy_exp[mg]) begin
        acc = 1;
        n_v = 1;
        n_d = s_dat[mg*W +: W];
        n_l = s_lst[mg];
        n_i = mg;
        qhd[mg]++;
        sent[mg]++;
        if (s_lst[mg]) begin
          n_b = 0;
          n_p = (mg + 1) % N;
        end
      end
      if (!acc && m_rdy) n_v = 0;
    end
    @(posedge clk);
    if (rst_n) begin
      mb = n_b; mg = n_g; mp = n_p; mv = n_v; md = n_d; ml = n_l; mi = n_i;
    end
    @(negedge clk);
  endtask

  task automatic run(input int cycles, input int rdy_pct);
    for (int c = 0; c < cycles; c++) begin
      m_rdy = ($urandom_range(99, 0) < rdy_pct);
      step();
    end
  endtask

  task automatic drain();
    bit done;
    m_rdy = 1;
    en    = '1;
    done  = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      step();
      done = !mb && !mv && all_empty();
    end
    check("drain_done", done, 1);
    if (done)
      for (int i = 0; i < N; i++) begin
        qhd[i] = 0;
        qtl[i] = 0;
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_s[6];
    rst_n = 1;
    m_rdy = 0;
    en    = '1;
    s_stb = '0;
    s_dat = '0;
    s_lst = '0;
    clear_all();
    model_reset();
    #1 rst_n = 0;

    // rotating-priority encoder on its own
    for (int t = 0; t < 64; t++) begin
      bit exp_any;
      bit found;
      int exp_sel;
      u_req = N'($urandom_range(15, 0));
      u_ptr = I'($urandom_range(3, 0));
      #1;
      exp_any = (u_req != '0);
      found   = 0;
      exp_sel = 0;
      for (int k = 0; k < N; k++)
        if (!found && u_req[(int'(u_ptr) + k) % N]) begin
          found   = 1;
          exp_sel = (int'(u_ptr) + k) % N;
        end
      check("rr_any", u_any, exp_any);
      if (exp_any) check("rr_sel", u_sel, exp_sel);
    end

    // reset held with every requester asserting
    push(0, 8'hA5, 1);
    push(1, 8'h31, 1);
    push(2, 8'h32, 1);
    push(3, 8'h33, 1);
    @(negedge clk);
    m_rdy = 1;
    repeat (3) step();
    rst_n = 1;
    step();
    step();
    check("rst_first_stb", m_stb, 1);
    check("rst_first_dat", m_dat, 8'hA5);
    check("rst_first_idx", m_idx, 0);
    drain();

    // fairness with continuous single-beat messages
    for (int i = 0; i < N; i++)
      for (int m = 0; m < 8; m++) push(i, W'(i * 16 + m), 1);
    out_log.delete();
    run(40, 100);
    check("fair_count", out_log.size() >= 8, 1);
    for (int j = 1; j < 8; j++)
      check("fair_seq", out_log[j] >> 8, ((out_log[j-1] >> 8) + 1) % N);
    drain();

    // message lock
    out_log.delete();
    push(1, 8'h10, 0);
    push(1, 8'h11, 0);
    push(1, 8'h12, 1);
    step();
    step();
    push(0, 8'h5A, 1);
    run(10, 100);
    check("lock_count", out_log.size(), 4);
    check("lock_b0", out_log[0], 32'h110);
    check("lock_b1", out_log[1], 32'h111);
    check("lock_b2", out_log[2], 32'h112);
    check("lock_b3", out_log[3], 32'h05A);
    drain();

    // backpressure: requester 2 granted (ptr is 1), output held 5 cycles
    push(2, 8'hB0, 0);
    push(2, 8'hB1, 0);
    push(2, 8'hB2, 1);
    push(3, 8'hC0, 1);
    m_rdy = 1;
    step();
    step();
    m_rdy = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_dat", m_dat, 8'hB0);
      check("bp_stb", m_stb, 1);
      check("bp_rdy", s_rdy[2], 0);
    end
    run(10, 100);
    drain();
    for (int i = 0; i < N; i++) check("bp_src_count", rcvd[i], sent[i]);

    // stall mid-message by the granted requester
    out_log.delete();
    for (int b = 0; b < 4; b++) push(3, W'(8'hD0 + b), b == 3);
    step();
    push(0, 8'hE0, 1);
    push(1, 8'hE1, 1);
    step();
    step();
    en[3] = 1'b0;
    repeat (4) step();
    en[3] = 1'b1;
    run(15, 100);
    exp_s = '{32'h3D0, 32'h3D1, 32'h3D2, 32'h3D3, 32'h0E0, 32'h1E1};
    check("stall_count", out_log.size(), 6);
    for (int j = 0; j < 6; j++) check("stall_seq", out_log[j], exp_s[j]);
    drain();

    // random traffic, stalls and backpressure
    for (int c = 0; c < 300; c++) begin
      int s;
      s = $urandom_range(N - 1, 0);
      if ($urandom_range(3, 0) == 0 && (qtl[s] - qhd[s]) < 8) push_msg(s, $urandom_range(4, 1));
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(9, 0) < 8);
      m_rdy = ($urandom_range(9, 0) < 7);
      step();
    end
    drain();
    for (int i = 0; i < N; i++) check("rand_src_count", rcvd[i], sent[i]);

    // async reset mid-message; ptr is left at 2 beforehand
    push(1, 8'h44, 1);
    drain();
    for (int b = 0; b < 4; b++) push(3, W'(8'hF0 + b), b == 3);
    m_rdy = 1;
    step();
    step();
    step();
    drive();
    #2 rst_n = 0;
    #1;
    check("async_m_stb", m_stb, 0);
    check("async_s_rdy", s_rdy, 0);
    model_reset();
    clear_all();
    @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1;
    push(2, 8'h77, 1);
    push(0, 8'h66, 1);
    step();
    step();
    check("restart_idx", m_idx, 0);
    check("restart_dat", m_dat, 8'h66);
    drain();
    for (int i = 0; i < N; i++) check("final_src_count", rcvd[i], sent[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
